fft_input_reorder: RTL and testbench

Upstream stage of the radix-2 DIT FFT. Accepts a natural-order stream of complex samples, buffers one frame per bank in a ping-pong buffer, and emits bit-reversed-order operand pairs (xp, xq) with an en strobe. The output drives the stage-0 butterfly inputs directly. The butterfly has no backpressure, so the output side never stalls.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_pp_bank.sv | 26 ++
 rtl/fft_input_reorder.sv | 144 ++++++++++++++
 tb/tb_fft_input_reorder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the complex sample type and the
// bit-reversal helper used by the reorder stage.
package fft_pkg;

  localparam int unsigned FFT_N     = 8;
  localparam int unsigned FFT_LOG2N = 3;
  localparam int unsigned FFT_DW    = 24;
  localparam int unsigned FFT_TW_W  = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r[5'(nbits - 1 - i)] = idx[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pp_bank.sv
// One ping-pong bank: N words, one synchronous write port and two
// combinational read ports fetching the even/odd word of a pair.
module fft_pp_bank #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3,
  parameter int unsigned WW = 48
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-2:0] rd_pair,
  output logic [WW-1:0] rdata_p,
  output logic [WW-1:0] rdata_q
);

  logic [WW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_p = mem[{rd_pair, 1'b0}];
  assign rdata_q = mem[{rd_pair, 1'b1}];

endmodule

// File: rtl/fft_input_reorder.sv
// FFT input stage: buffers natural-order frames in a ping-pong store and
// emits bit-reversed operand pairs for the stage-0 butterfly.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned LOG2N = FFT_LOG2N,
  parameter int unsigned DW    = FFT_DW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_en,
  output logic                 out_sof,
  output logic signed [DW-1:0] xp_real,
  output logic signed [DW-1:0] xp_imag,
  output logic signed [DW-1:0] xq_real,
  output logic signed [DW-1:0] xq_imag
);

  localparam int unsigned PW = LOG2N - 1;
  localparam int unsigned WW = 2 * DW;

  logic [LOG2N-1:0] wr_cnt, wr_cnt_nxt;
  logic [PW-1:0]    rd_cnt, rd_cnt_nxt;
  logic             wr_bank, wr_bank_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic [1:0]       bank_full, bank_full_nxt;

  logic             wr_fire, rd_act;
  logic [LOG2N-1:0] wr_addr;
  logic [WW-1:0]    wdata;
  logic [WW-1:0]    rd_p0, rd_q0, rd_p1, rd_q1, rd_p, rd_q;

  assign in_ready = !bank_full[wr_bank];
  assign wr_fire  = in_valid & in_ready & ~clr;
  assign rd_act   = bank_full[rd_bank];
  assign wr_addr  = LOG2N'(bitrev(32'(wr_cnt), LOG2N));
  assign wdata    = {in_real, in_imag};

  // Write-complete sets wr_bank's flag while read-complete clears rd_bank's;
  // they never target the same bank because a full wr_bank blocks writes.
  always_comb begin
    wr_cnt_nxt    = wr_cnt;
    rd_cnt_nxt    = rd_cnt;
    wr_bank_nxt   = wr_bank;
    rd_bank_nxt   = rd_bank;
    bank_full_nxt = bank_full;
    if (wr_fire) begin
      if (wr_cnt == LOG2N'(N - 1)) begin
        bank_full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt            = ~wr_bank;
        wr_cnt_nxt             = '0;
      end else begin
        wr_cnt_nxt = wr_cnt + 1'b1;
      end
    end
    if (rd_act) begin
      if (rd_cnt == PW'(N / 2 - 1)) begin
        bank_full_nxt[rd_bank] = 1'b0;
        rd_bank_nxt            = ~rd_bank;
        rd_cnt_nxt             = '0;
      end else begin
        rd_cnt_nxt = rd_cnt + 1'b1;
      end
    end
    if (clr) begin
      wr_cnt_nxt    = '0;
      rd_cnt_nxt    = '0;
      wr_bank_nxt   = 1'b0;
      rd_bank_nxt   = 1'b0;
      bank_full_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= '0;
    end else begin
      wr_cnt    <= wr_cnt_nxt;
      rd_cnt    <= rd_cnt_nxt;
      wr_bank   <= wr_bank_nxt;
      rd_bank   <= rd_bank_nxt;
      bank_full <= bank_full_nxt;
    end
  end

  fft_pp_bank #(.N(N), .AW(LOG2N), .WW(WW)) u_bank0 (
    .clk     (clk),
    .we      (wr_fire & ~wr_bank),
    .waddr   (wr_addr),
    .wdata   (wdata),
    .rd_pair (rd_cnt),
    .rdata_p (rd_p0),
    .rdata_q (rd_q0)
  );

  fft_pp_bank #(.N(N), .AW(LOG2N), .WW(WW)) u_bank1 (
    .clk     (clk),
    .we      (wr_fire & wr_bank),
    .waddr   (wr_addr),
    .wdata   (wdata),
    .rd_pair (rd_cnt),
    .rdata_p (rd_p1),
    .rdata_q (rd_q1)
  );

  assign rd_p = rd_bank ? rd_p1 : rd_p0;
  assign rd_q = rd_bank ? rd_q1 : rd_q0;

  // Operand registers only load on a read cycle, so they hold between frames
  // and across clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_en  <= 1'b0;
      out_sof <= 1'b0;
      xp_real <= '0;
      xp_imag <= '0;
      xq_real <= '0;
      xq_imag <= '0;
    end else if (clr) begin
      out_en  <= 1'b0;
      out_sof <= 1'b0;
    end else begin
      out_en  <= rd_act;
      out_sof <= rd_act && (rd_cnt == '0);
      if (rd_act) begin
        xp_real <= rd_p[WW-1:DW];
        xp_imag <= rd_p[DW-1:0];
        xq_real <= rd_q[WW-1:DW];
        xq_imag <= rd_q[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder: directed and random frames
// checked against a frame-level schedule of expected output pairs.
module tb_fft_input_reorder;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int DW    = 24;
  localparam int NP    = N / 2;

  logic clk = 1'b0;
  logic rstn, clr, in_valid, in_ready, out_en, out_sof;
  logic signed [DW-1:0] in_real, in_imag;
  logic signed [DW-1:0] xp_real, xp_imag, xq_real, xq_imag;

  fft_input_reorder #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_en   (out_en),
    .out_sof  (out_sof),
    .xp_real  (xp_real),
    .xp_imag  (xp_imag),
    .xq_real  (xq_real),
    .xq_imag  (xq_imag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] pr, pi, qr, qi;
    bit            sof;
  } pair_t;

  pair_t           exp_at[int];
  int              clear_q[$];
  int              free_at = 0;
  int              cyc = 0;
  int              wcount = 0;
  logic [DW-1:0]   fr_r[N];
  logic [DW-1:0]   fr_i[N];
  logic [4*DW-1:0] last_data = '0;
  int              n_cmp = 0;
  int              n_bad = 0;
  bit              mon_on = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bitrev_ref(input int w);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (w % 2);
      w = w / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s @edge %0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int occ(input int t);
    int n = 0;
    foreach (clear_q[j]) if (clear_q[j] > t) n++;
    return n;
  endfunction

  task automatic model_flush();
    exp_at.delete();
    clear_q.delete();
    free_at = 0;
    wcount  = 0;
  endtask

  // Frame completed at edge a: pairs come out one per edge, no earlier than
  // a+1 and not before the previous frame's pairs have all left.
  task automatic schedule(input int a);
    int    start;
    pair_t e;
    start = (a + 1 > free_at) ? a + 1 : free_at;
    for (int k = 0; k < NP; k++) begin
      e.pr  = fr_r[bitrev_ref(2 * k)];
      e.pi  = fr_i[bitrev_ref(2 * k)];
      e.qr  = fr_r[bitrev_ref(2 * k + 1)];
      e.qi  = fr_i[bitrev_ref(2 * k + 1)];
      e.sof = (k == 0);
      exp_at[start + k] = e;
    end
    clear_q.push_back(start + NP - 1);
    free_at = start + NP;
  endtask

  task automatic step(input bit v, input bit c, input logic [DW-1:0] r, input logic [DW-1:0] i,
                      output bit took);
    int a;
    bit rdy;
    rdy = (occ(cyc) < 2);
    chk("in_ready", in_ready, rdy);
    in_valid = v;
    clr      = c;
    in_real  = r;
    in_imag  = i;
    a = cyc + 1;
    @(posedge clk);
    took = 0;
    if (c) begin
      model_flush();
    end else if (v && rdy) begin
      took = 1;
      fr_r[wcount] = r;
      fr_i[wcount] = i;
      wcount++;
      if (wcount == N) begin
        schedule(a);
        wcount = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) step(0, 0, '0, '0, t);
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i);
    bit took = 0;
    for (int tries = 0; tries < 50 && !took; tries++) step(1, 0, r, i, took);
    if (!took) chk("accept_timeout", took, 1'b1);
  endtask

  task automatic send_seq_frame();
    for (int k = 0; k < N; k++) send(DW'(k + 1), DW'(-(k + 1)));
  endtask

  task automatic send_rand_frame(input bit gappy);
    for (int k = 0; k < N; k++) begin
      send(DW'($urandom), DW'($urandom));
      if (gappy && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic do_reset();
    in_valid = 0;
    clr      = 0;
    rstn     = 0;
    model_flush();
    last_data = '0;
    repeat (3) @(negedge clk);
    chk("in_ready_in_reset", in_ready, 1'b1);
    rstn = 1;
  endtask

  // Output monitor: out_en/out_sof/operands against the expected schedule.
  always begin
    @(posedge clk);
    #2;
    if (mon_on) begin : mon
      pair_t e;
      bit    has;
      has = exp_at.exists(cyc);
      chk("out_en", out_en, has);
      if (has) begin
        e = exp_at[cyc];
        last_data = {e.pr, e.pi, e.qr, e.qi};
        chk("out_sof", out_sof, e.sof);
      end else begin
        chk("out_sof_idle", out_sof, 1'b0);
      end
      chk("out_data", {xp_real, xp_imag, xq_real, xq_imag}, last_data);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    bit t;
    rstn = 0; clr = 0; in_valid = 0; in_real = '0; in_imag = '0;
    @(negedge clk);
    mon_on = 1;
    repeat (2) @(negedge clk);
    chk("reset_out", {out_en, out_sof, xp_real, xp_imag, xq_real, xq_imag}, '0);
    rstn = 1;

    // ramp frame, full rate
    send_seq_frame();
    idle(8);

    // three back-to-back random frames at full rate
    repeat (3) send_rand_frame(0);
    idle(8);

    // valid toggling 1,0,1,0
    for (int k = 0; k < N; k++) begin
      send(DW'($urandom), DW'($urandom));
      idle(1);
    end
    idle(8);

    // extreme values, alternating sign limits
    for (int k = 0; k < N; k++)
      send((k % 2 == 1) ? 24'h800000 : 24'h7FFFFF, (k % 2 == 1) ? 24'h7FFFFF : 24'h800000);
    idle(8);

    // partial frame discarded by reset
    for (int k = 0; k < 5; k++) send(DW'(100 + k), DW'(200 + k));
    do_reset();
    chk("post_reset_out", {out_en, out_sof, xp_real, xp_imag, xq_real, xq_imag}, '0);
    send_seq_frame();
    idle(8);

    // partial frame discarded by clr, with a transfer offered in the clr cycle
    for (int k = 0; k < 5; k++) send(DW'(300 + k), DW'(400 + k));
    step(1, 1, 24'h123456, 24'h654321, t);
    chk("clr_drops_transfer", t, 1'b0);
    send_seq_frame();
    idle(8);

    // clr in the middle of an output burst
    send_seq_frame();
    idle(2);
    step(0, 1, '0, '0, t);
    idle(4);
    send_seq_frame();
    idle(8);

    // random frames with random input gaps
    repeat (6) send_rand_frame(1);
    idle(10);

    in_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
